// File: rtl/writeback_regfile_pkg.sv
// rtl/writeback_regfile_pkg.sv - shared pipeline constants for MEMORY and writeback
package writeback_regfile_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - MEMORY->writeback, decode read and debug signal bundle
interface writeback_regfile_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0] MW_ALUout;
  logic [4:0]        MW_RD;
  logic [4:0]        ID_RS;
  logic [4:0]        ID_RT;
  logic [DATA_W-1:0] RS_data;
  logic [DATA_W-1:0] RT_data;
  logic [4:0]        WB_RD;
  logic [DATA_W-1:0] WB_DATA;
  logic [CNT_W-1:0]  WR_CNT;
  logic [4:0]        DBG_ADDR;
  logic [DATA_W-1:0] DBG_DATA;

  modport master (
    output MW_ALUout, MW_RD, ID_RS, ID_RT, DBG_ADDR,
    input  RS_data, RT_data, WB_RD, WB_DATA, WR_CNT, DBG_DATA
  );

  modport slave (
    input  MW_ALUout, MW_RD, ID_RS, ID_RT, DBG_ADDR,
    output RS_data, RT_data, WB_RD, WB_DATA, WR_CNT, DBG_DATA
  );
endinterface

// File: rtl/writeback_regfile_rf.sv
// rtl/writeback_regfile_rf.sv - 32-entry register array, two read ports plus debug read, one write port
// No bypass here: reads return stored contents; entry 0 is never written and reads as 0.
module regfile_2r1w
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  reg_addr_t         wa,
  input  logic [DATA_W-1:0] wd,
  input  reg_addr_t         ra_a,
  input  reg_addr_t         ra_b,
  input  reg_addr_t         ra_dbg,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] rd_dbg
);
  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && wa != REG_ZERO) begin
      mem[wa] <= wd;
    end
  end

  assign rd_a   = (ra_a   == REG_ZERO) ? '0 : mem[ra_a];
  assign rd_b   = (ra_b   == REG_ZERO) ? '0 : mem[ra_b];
  assign rd_dbg = (ra_dbg == REG_ZERO) ? '0 : mem[ra_dbg];
endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback stage: register file with same-cycle bypass, WB forwarding regs, write counter
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  writeback_regfile_if.slave bus
);
  logic              wr_en;
  logic [DATA_W-1:0] arr_a;
  logic [DATA_W-1:0] arr_b;

  assign wr_en = (bus.MW_RD != REG_ZERO);

  regfile_2r1w #(.DATA_W(DATA_W)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_en),
    .wa     (bus.MW_RD),
    .wd     (bus.MW_ALUout),
    .ra_a   (bus.ID_RS),
    .ra_b   (bus.ID_RT),
    .ra_dbg (bus.DBG_ADDR),
    .rd_a   (arr_a),
    .rd_b   (arr_b),
    .rd_dbg (bus.DBG_DATA)
  );

  // Decode sees the retiring write in the same cycle; this also holds while rst is high.
  always_comb begin
    bus.RS_data = arr_a;
    bus.RT_data = arr_b;
    if (bus.ID_RS == REG_ZERO)   bus.RS_data = '0;
    else if (bus.ID_RS == bus.MW_RD) bus.RS_data = bus.MW_ALUout;
    if (bus.ID_RT == REG_ZERO)   bus.RT_data = '0;
    else if (bus.ID_RT == bus.MW_RD) bus.RT_data = bus.MW_ALUout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.WB_RD   <= REG_ZERO;
      bus.WB_DATA <= '0;
      bus.WR_CNT  <= '0;
    end else if (wr_en) begin
      bus.WB_RD   <= bus.MW_RD;
      bus.WB_DATA <= bus.MW_ALUout;
      bus.WR_CNT  <= bus.WR_CNT + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - self-checking bench for writeback_regfile (DATA_W=32, CNT_W=4)
`timescale 1ns/1ps
module tb_writeback_regfile;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  writeback_regfile_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  writeback_regfile #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: architectural registers, last retired write, write count mod 2^CW.
  logic [DW-1:0] m_rf [32];
  logic [4:0]    m_wb_rd;
  logic [DW-1:0] m_wb_data;
  int            m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
      m_wb_rd   <= '0;
      m_wb_data <= '0;
      m_cnt     <= 0;
    end else if (bus.MW_RD != 5'd0) begin
      m_rf[bus.MW_RD] <= bus.MW_ALUout;
      m_wb_rd         <= bus.MW_RD;
      m_wb_data       <= bus.MW_ALUout;
      m_cnt           <= (m_cnt + 1) % (1 << CW);
    end
  end

  function automatic logic [DW-1:0] exp_read(logic [4:0] ra);
    if (ra == 5'd0) return '0;
    if (ra == bus.MW_RD) return bus.MW_ALUout;
    return m_rf[ra];
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_rs",    bus.RS_data,  exp_read(bus.ID_RS));
    chk("cmp_rt",    bus.RT_data,  exp_read(bus.ID_RT));
    chk("cmp_dbg",   bus.DBG_DATA, m_rf[bus.DBG_ADDR]);
    chk("cmp_wbrd",  32'(bus.WB_RD),  32'(m_wb_rd));
    chk("cmp_wbdat", bus.WB_DATA,  m_wb_data);
    chk("cmp_cnt",   32'(bus.WR_CNT), 32'(m_cnt));
  end

  task automatic drive(input logic [4:0] rd, input logic [DW-1:0] d,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
    bus.MW_RD     = rd;
    bus.MW_ALUout = d;
    bus.ID_RS     = rs;
    bus.ID_RT     = rt;
    bus.DBG_ADDR  = dbg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #2;
    chk("rst_cnt",  32'(bus.WR_CNT), 32'd0);
    chk("rst_wbrd", 32'(bus.WB_RD), 32'd0);
    chk("rst_wbd",  bus.WB_DATA, 32'd0);
    tick();
    rst = 1'b0;

    // Same-cycle bypass on both ports; debug port sees the write only after the edge.
    drive(5'd7, 32'hDEADBEEF, 5'd7, 5'd7, 5'd7);
    #1;
    chk("byp_rs7", bus.RS_data, 32'hDEADBEEF);
    chk("byp_rt7", bus.RT_data, 32'hDEADBEEF);
    chk("dbg7_pre", bus.DBG_DATA, 32'h0);
    tick();
    chk("dbg7_post", bus.DBG_DATA, 32'hDEADBEEF);
    chk("cnt_1", 32'(bus.WR_CNT), 32'd1);

    // Bubble with all-ones data must not write or update anything.
    drive(5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 5'd7);
    #1;
    chk("bub_rs0", bus.RS_data, 32'h0);
    tick();
    chk("bub_cnt", 32'(bus.WR_CNT), 32'd1);
    chk("bub_wbrd", 32'(bus.WB_RD), 32'd7);
    chk("bub_dbg7", bus.DBG_DATA, 32'hDEADBEEF);

    for (int i = 0; i < 32; i++) begin
      drive(5'd0, 32'hA5A50000 | i, 5'(i), 5'(31 - i), 5'(i));
      tick();
    end

    // Back-to-back writes to r9.
    for (int v = 1; v <= 3; v++) begin
      drive(5'd9, DW'(v), 5'd9, 5'd9, 5'd9);
      #1;
      chk("b2b_rs9", bus.RS_data, DW'(v));
      chk("b2b_rt9", bus.RT_data, DW'(v));
      chk("b2b_dbg9", bus.DBG_DATA, DW'(v - 1));
      tick();
    end
    drive(5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
    #1;
    chk("r9_final", bus.DBG_DATA, 32'd3);
    chk("r9_rs", bus.RS_data, 32'd3);
    tick();

    // WB forwarding regs hold through bubbles.
    drive(5'd3, 32'h11, 5'd0, 5'd0, 5'd3);
    tick();
    for (int b = 0; b < 3; b++) begin
      drive(5'd0, 32'h5555AAAA + b, 5'd3, 5'd1, 5'd3);
      tick();
      chk("hold_wbrd", 32'(bus.WB_RD), 32'd3);
      chk("hold_wbd", bus.WB_DATA, 32'h11);
    end

    // Mid-cycle asynchronous reset.
    drive(5'd5, 32'h1234, 5'd0, 5'd0, 5'd5);
    tick();
    drive(5'd0, 32'h0, 5'd0, 5'd0, 5'd5);
    #1;
    chk("r5_pre_rst", bus.DBG_DATA, 32'h1234);
    rst = 1'b1;
    #1;
    chk("arst_r5", bus.DBG_DATA, 32'h0);
    chk("arst_cnt", 32'(bus.WR_CNT), 32'd0);
    chk("arst_wbrd", 32'(bus.WB_RD), 32'd0);
    tick();
    rst = 1'b0;

    // 17 writes with a 4-bit counter: 15, then wrap to 0, then 1.
    for (int i = 1; i <= 17; i++) begin
      drive(5'((i % 31) + 1), 32'h100 + i, 5'd2, 5'd3, 5'((i % 31) + 1));
      tick();
      if (i == 15) chk("cnt_15", 32'(bus.WR_CNT), 32'd15);
      if (i == 16) chk("cnt_wrap0", 32'(bus.WR_CNT), 32'd0);
      if (i == 17) chk("cnt_wrap1", 32'(bus.WR_CNT), 32'd1);
    end

    // Reset during a pending write discards it; bypass stays live in reset.
    drive(5'd4, 32'hCAFE, 5'd4, 5'd4, 5'd4);
    #1;
    rst = 1'b1;
    #1;
    chk("rstbyp_rs", bus.RS_data, 32'hCAFE);
    chk("rstbyp_rt", bus.RT_data, 32'hCAFE);
    chk("rstbyp_dbg", bus.DBG_DATA, 32'h0);
    drive(5'd4, 32'hCAFE, 5'd4, 5'd6, 5'd4);
    #1;
    chk("rst_rd0", bus.RT_data, 32'h0);
    tick();
    chk("rstwr_dbg", bus.DBG_DATA, 32'h0);
    chk("rstwr_cnt", 32'(bus.WR_CNT), 32'd0);
    rst = 1'b0;
    drive(5'd4, 32'hBEEF, 5'd4, 5'd4, 5'd4);
    tick();
    chk("post_rst_dbg", bus.DBG_DATA, 32'hBEEF);
    chk("post_rst_cnt", 32'(bus.WR_CNT), 32'd1);
    chk("post_rst_wbrd", 32'(bus.WB_RD), 32'd4);
    chk("post_rst_wbd", bus.WB_DATA, 32'hBEEF);
    drive(5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as the register and write-data width.
REQ-002 The block SHALL take parameter CNT_W, default 32, as the width of the write counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock shared with the MEMORY stage.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 MW_ALUout  input  DATA_W  write data from the MEMORY stage (ALU result or loaded word).
REQ-007 MW_RD  input  5  destination register; 0 means no write (bubble or suppressed writeback).
REQ-008 ID_RS  input  5  decode read address A.
REQ-009 ID_RT  input  5  decode read address B.
REQ-010 RS_data  output  DATA_W  read port A data.
REQ-011 RT_data  output  DATA_W  read port B data.
REQ-012 WB_RD  output  5  registered destination of the last retired write, for EX forwarding.
REQ-013 WB_DATA  output  DATA_W  registered data of the last retired write.
REQ-014 WR_CNT  output  CNT_W  count of register writes since reset.
REQ-015 DBG_ADDR  input  5  debug read address.
REQ-016 DBG_DATA  output  DATA_W  debug read data, array contents only, no bypass.

Function
REQ-017 The register file SHALL hold 32 entries of DATA_W bits, and entry 0 SHALL always read as 0.
REQ-018 On each rising clk edge with MW_RD != 0, the block SHALL set RF[MW_RD] to MW_ALUout.
REQ-019 When MW_RD == 0, no entry SHALL change, WB_RD/WB_DATA SHALL hold, and WR_CNT SHALL hold.
REQ-020 RS_data SHALL be combinational: 0 if ID_RS == 0; else MW_ALUout if ID_RS == MW_RD; else RF[ID_RS].
REQ-021 RT_data SHALL follow the same rule as RS_data, using ID_RT.
REQ-022 Both read ports SHALL give the correct value in the same cycle even when ID_RS == ID_RT == MW_RD.
REQ-023 On a write edge, the block SHALL set WB_RD to MW_RD and WB_DATA to MW_ALUout, a latency of 1 cycle.
REQ-024 WR_CNT SHALL increment by 1 on each write edge and SHALL wrap from 2^CNT_W-1 to 0.
REQ-025 DBG_DATA SHALL equal RF[DBG_ADDR] combinationally, and SHALL return 0 for address 0.
REQ-026 A write edge SHALL be visible on DBG_DATA only after that edge.

Reset
REQ-027 While rst is high, all 31 writable entries, WB_RD, WB_DATA and WR_CNT SHALL be 0, taking effect immediately and asynchronously.
REQ-028 If rst asserts in the same cycle as a pending write, the write SHALL be discarded.
REQ-029 During reset, the read ports SHALL still bypass MW_ALUout when ID_RS/ID_RT == MW_RD != 0; otherwise they SHALL read 0.
REQ-030 The first edge after rst deasserts SHALL perform a normal write.

Structure
REQ-031 A shared pipeline package SHALL hold REG_ZERO (5'd0), NUM_REGS (32) and the data width constant that MEMORY and writeback_regfile both use.
REQ-032 The block SHALL contain one sub-module, regfile_2r1w: the 32-entry array with two read ports and one write port, without bypass.
REQ-033 The top level SHALL hold the bypass mux, the WB forwarding registers and the write counter.

Verification
REQ-034 The bench SHALL assert rst mid-cycle after writing RF[5]=0x1234 and check RF[5]=0, WR_CNT=0, WB_RD=0 immediately, with no clock edge.
REQ-035 The bench SHALL drive MW_RD=7, MW_ALUout=0xDEADBEEF, ID_RS=ID_RT=7 and check RS_data=RT_data=0xDEADBEEF in the same cycle and DBG_DATA(7)=0xDEADBEEF only after the edge.
REQ-036 The bench SHALL drive MW_RD=0, MW_ALUout=0xFFFFFFFF, ID_RS=0 and check RS_data=0, no entry changed, and WR_CNT/WB_RD unchanged.
REQ-037 The bench SHALL write RF[3]=0x11 and then insert 3 bubbles, and check WB_RD=3 and WB_DATA=0x11 held through all three bubbles.
REQ-038 The bench SHALL build with CNT_W=4, perform 17 writes, and check that WR_CNT reads 15 then 0 then 1.
REQ-039 The bench SHALL perform back-to-back writes to RF[9] with values 1, 2, 3 and check the bypass each cycle and RF[9]=3 at the end.
